tic_tac_toe_sequencer: RTL and testbench
========================================

# tic_tac_toe_sequencer

Turn sequencer for the tic-tac-toe VGA game. Consumes the synchronized one-cycle button pulses and the one-second tick, then owns the 3x3 board, cursor position, current player, per-turn countdown and win/draw detection. Its board and cursor outputs feed the cursor box and color control logic. It runs in the 25 MHz pixel clock domain.

## Interface
- TURN_SECONDS, 10, seconds allowed per turn; legal range 1..15.
- clk  in  1  25 MHz pixel clock.
- rst  in  1  asynchronous active-low reset.
- move_pulse  in  1  one-cycle pulse that advances the cursor.
- sel_pulse  in  1  one-cycle pulse that places a mark, or restarts the game when it is over.
- tick_1s  in  1  one-cycle pulse, once per second.
- cursor  out  4  selected cell, 0..8; cell index = row*3 + col.
- board  out  18  cell i is held in board[2i+1:2i]; 00 empty, 01 X, 10 O.
- turn  out  1  current player; 0 = X, 1 = O.
- timer  out  4  seconds remaining in the current turn.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- win_line  out  8  mask of completed lines, valid in OVER. Bits 0-2 are rows 0-2, bits 3-5 are cols 0-2, bit 6 is diagonal {0,4,8}, bit 7 is anti-diagonal {2,4,6}.
- invalid  out  1  one-cycle pulse when a select targets an occupied cell.
- timeout  out  1  one-cycle pulse when a turn expires.

## Operation
- States: PLAY, CHECK, OVER.
- Reset values: state PLAY, board 0, cursor 0, turn 0, timer TURN_SECONDS, game_over 0, winner 00, win_line 0, invalid 0, timeout 0.
- PLAY, priority sel > move > tick. Only the highest-priority pulse present in a cycle acts; the others are dropped.
  - sel_pulse on an empty cursor cell: write the mark {turn, ~turn}, then go to CHECK.
  - sel_pulse on an occupied cell: pulse invalid; no other change.
  - move_pulse: cursor = (cursor == 8) ? 0 : cursor + 1.
  - tick_1s with timer > 1: timer decrements by 1.
  - tick_1s with timer == 1: pulse timeout, toggle turn, reload timer = TURN_SECONDS, board unchanged.
- CHECK lasts exactly one cycle. It evaluates all 8 lines on the registered board for the player who just moved. All input pulses are dropped in CHECK.
  - Any line complete: winner = 01 or 10, win_line = the completed lines (more than one bit may be set), go to OVER.
  - Otherwise, all 9 cells occupied: winner = 11, win_line = 0, go to OVER.
  - Otherwise: toggle turn, reload timer, return to PLAY.
- OVER: game_over = 1. board, turn, timer and cursor are frozen. move_pulse and tick_1s are ignored.
  - sel_pulse restarts the game: board 0, cursor 0, turn 0, timer reload, winner 00, win_line 0, go to PLAY.
- Reset asserted in any state, including mid-CHECK, immediately forces the reset values.

## Timing
- All outputs are registered. invalid and timeout are high for exactly one cycle.
- sel_pulse on an empty cell at edge n:
  - board and state (CHECK) update at n+1.
  - turn/timer, or winner/win_line/game_over, update at n+2.
- move_pulse at edge n: cursor updates at n+1.
- tick_1s at edge n: timer updates at n+1. On expiry, turn and timeout also update at n+1.
- Restart from OVER: sel at edge n, PLAY with cleared state at n+1.
- Minimum spacing between accepted selects is 2 cycles.

## Test plan
- Reset, then 9 move_pulses: cursor steps 1..8, then wraps to 0. board = 0, turn = 0, timer = 10.
- X plays cells 0, O 3, X 1, O 4, X 2 (move/sel sequences): 2 cycles after the last select, winner = 01, win_line = 0x01, game_over = 1. Further moves and ticks do not change cursor or timer.
- Select an occupied cell: invalid pulses for one cycle; board and turn unchanged. Assert sel_pulse and move_pulse in the same cycle on an empty cell: mark placed, cursor unchanged.
- 10 tick_1s pulses with no select: timer counts 10 down to 1. The 10th tick produces a timeout pulse, turn = 1, timer = 10.
- Draw sequence (X 0, O 1, X 2, O 4, X 3, O 5, X 7, O 6, X 8): winner = 11, win_line = 0. A following sel_pulse clears the board, sets turn = 0 and winner = 00.
- Drop rst low for one cycle during CHECK: all outputs return to reset values asynchronously, and the interrupted move is not scored.

Source files
------------

// File: rtl/tic_tac_toe_sequencer.sv
// rtl/tic_tac_toe_sequencer.sv - turn sequencer: board, cursor, player, turn timer, win/draw detection
module tic_tac_toe_sequencer #(
    parameter int unsigned TURN_SECONDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_pulse,
    input  logic        sel_pulse,
    input  logic        tick_1s,
    output logic [3:0]  cursor,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  timer,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic        invalid,
    output logic        timeout
);

    localparam logic [3:0] RELOAD = 4'(TURN_SECONDS);

    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic        turn_q, turn_d;
    logic [3:0]  timer_q, timer_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  win_line_q, win_line_d;
    logic        invalid_q, invalid_d;
    logic        timeout_q, timeout_d;

    logic [1:0]  mark;
    logic [8:0]  mine;
    logic [8:0]  occ;
    logic [7:0]  lines;
    logic [4:0]  cur_idx;
    logic        cur_occ;

    // The mover's mark doubles as the pattern searched for in CHECK, since turn only toggles afterwards.
    assign mark    = {turn_q, ~turn_q};
    assign cur_idx = {cursor_q, 1'b0};
    assign cur_occ = |board_q[cur_idx +: 2];

    always_comb begin
        mine = '0;
        occ  = '0;
        for (int i = 0; i < 9; i++) begin
            mine[i] = (board_q[2*i +: 2] == mark);
            occ[i]  = |board_q[2*i +: 2];
        end
    end

    assign lines = {mine[2] & mine[4] & mine[6],
                    mine[0] & mine[4] & mine[8],
                    mine[2] & mine[5] & mine[8],
                    mine[1] & mine[4] & mine[7],
                    mine[0] & mine[3] & mine[6],
                    &mine[8:6],
                    &mine[5:3],
                    &mine[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PLAY;
            board_q     <= '0;
            cursor_q    <= '0;
            turn_q      <= 1'b0;
            timer_q     <= RELOAD;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            win_line_q  <= '0;
            invalid_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            cursor_q    <= cursor_d;
            turn_q      <= turn_d;
            timer_q     <= timer_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            win_line_q  <= win_line_d;
            invalid_q   <= invalid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLAY:  if (sel_pulse && !cur_occ) state_d = S_CHECK;
            S_CHECK: state_d = ((|lines) || (&occ)) ? S_OVER : S_PLAY;
            S_OVER:  if (sel_pulse) state_d = S_PLAY;
            default: state_d = S_PLAY;
        endcase
    end

    always_comb begin
        board_d     = board_q;
        cursor_d    = cursor_q;
        turn_d      = turn_q;
        timer_d     = timer_q;
        winner_d    = winner_q;
        win_line_d  = win_line_q;
        invalid_d   = 1'b0;
        timeout_d   = 1'b0;
        game_over_d = (state_d == S_OVER);
        case (state_q)
            S_PLAY: begin
                // Only the highest-priority pulse acts; lower ones are dropped.
                if (sel_pulse) begin
                    if (cur_occ) invalid_d = 1'b1;
                    else         board_d[cur_idx +: 2] = mark;
                end else if (move_pulse) begin
                    cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
                end else if (tick_1s) begin
                    if (timer_q > 4'd1) begin
                        timer_d = timer_q - 4'd1;
                    end else begin
                        timeout_d = 1'b1;
                        turn_d    = ~turn_q;
                        timer_d   = RELOAD;
                    end
                end
            end
            S_CHECK: begin
                if (|lines) begin
                    winner_d   = mark;
                    win_line_d = lines;
                end else if (&occ) begin
                    winner_d   = 2'b11;
                    win_line_d = '0;
                end else begin
                    turn_d  = ~turn_q;
                    timer_d = RELOAD;
                end
            end
            S_OVER: begin
                if (sel_pulse) begin
                    board_d    = '0;
                    cursor_d   = '0;
                    turn_d     = 1'b0;
                    timer_d    = RELOAD;
                    winner_d   = 2'b00;
                    win_line_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign cursor    = cursor_q;
    assign board     = board_q;
    assign turn      = turn_q;
    assign timer     = timer_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign invalid   = invalid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_tic_tac_toe_sequencer.sv
// tb/tb_tic_tac_toe_sequencer.sv - table, hand-sequence and random checks against a board-level model
module tb_tic_tac_toe_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_pulse = 1'b0, sel_pulse = 1'b0, tick_1s = 1'b0;
    logic [3:0]  cursor, timer;
    logic [17:0] board;
    logic        turn, game_over, invalid, timeout;
    logic [1:0]  winner;
    logic [7:0]  win_line;

    tic_tac_toe_sequencer #(.TURN_SECONDS(10)) dut (
        .clk(clk), .rst(rst), .move_pulse(move_pulse), .sel_pulse(sel_pulse), .tick_1s(tick_1s),
        .cursor(cursor), .board(board), .turn(turn), .timer(timer), .game_over(game_over),
        .winner(winner), .win_line(win_line), .invalid(invalid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model: cells as integers 0 empty, 1 X, 2 O.
    int m_cell[9];
    int m_cursor, m_turn, m_timer, m_winner, m_line, m_phase;   // phase 0 play, 1 just placed, 2 over
    bit m_inv, m_to;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [39:0] pk(int c, logic [17:0] b, int t, int tm, int ov, int w, int wl, int iv, int to);
        return {4'(c), b, 1'(t), 4'(tm), 1'(ov), 2'(w), 8'(wl), 1'(iv), 1'(to)};
    endfunction

    function automatic logic [39:0] model_bundle();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return pk(m_cursor, b, m_turn, m_timer, (m_phase == 2) ? 1 : 0, m_winner, m_line, m_inv, m_to);
    endfunction

    function automatic void model_reset();
        foreach (m_cell[i]) m_cell[i] = 0;
        m_cursor = 0; m_turn = 0; m_timer = 10; m_winner = 0; m_line = 0; m_phase = 0;
        m_inv = 0; m_to = 0;
    endfunction

    function automatic void model_step(bit s, bit m, bit t);
        int mk, mask, filled;
        m_inv = 0; m_to = 0;
        if (m_phase == 1) begin
            mk = m_turn + 1;
            mask = 0; filled = 0;
            for (int l = 0; l < 8; l++)
                if (m_cell[lines[l][0]] == mk && m_cell[lines[l][1]] == mk && m_cell[lines[l][2]] == mk)
                    mask += (1 << l);
            foreach (m_cell[i]) if (m_cell[i] != 0) filled++;
            if (mask != 0) begin m_winner = mk; m_line = mask; m_phase = 2; end
            else if (filled == 9) begin m_winner = 3; m_line = 0; m_phase = 2; end
            else begin m_turn = 1 - m_turn; m_timer = 10; m_phase = 0; end
        end else if (m_phase == 2) begin
            if (s) model_reset();
        end else if (s) begin
            if (m_cell[m_cursor] != 0) m_inv = 1;
            else begin m_cell[m_cursor] = m_turn + 1; m_phase = 1; end
        end else if (m) begin
            m_cursor = (m_cursor + 1) % 9;
        end else if (t) begin
            if (m_timer > 1) m_timer--;
            else begin m_to = 1; m_turn = 1 - m_turn; m_timer = 10; end
        end
    endfunction

    function automatic logic [39:0] dut_bundle();
        return {cursor, board, turn, timer, game_over, winner, win_line, invalid, timeout};
    endfunction

    task automatic check(string name, logic [39:0] act, logic [39:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(bit s, bit m, bit t);
        sel_pulse = s; move_pulse = m; tick_1s = t;
        @(posedge clk);
        model_step(s, m, t);
        #1;
        sel_pulse = 0; move_pulse = 0; tick_1s = 0;
        check("model", dut_bundle(), model_bundle());
    endtask

    task automatic play_cell(int target);
        int guard = 0;
        while (m_cursor != target && guard < 9) begin step(0, 1, 0); guard++; end
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    typedef struct {
        bit s, m, t;
        int rep;
        logic [39:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic add(bit s, bit m, bit t, int rep, logic [39:0] exp);
        vec_t v;
        v.s = s; v.m = m; v.t = t; v.rep = rep; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        // Win on row 0: X 0, O 3, X 1, O 4, X 2; then frozen OVER and restart.
        add(0,1,0, 8, pk(8, 18'h0,     0, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 1, pk(0, 18'h0,     0, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(0, 18'h00001, 0, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(0, 18'h00001, 1, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 3, pk(3, 18'h00001, 1, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(3, 18'h00081, 1, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(3, 18'h00081, 0, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 7, pk(1, 18'h00081, 0, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(1, 18'h00085, 0, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(1, 18'h00085, 1, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 3, pk(4, 18'h00085, 1, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(4, 18'h00285, 1, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(4, 18'h00285, 0, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 7, pk(2, 18'h00285, 0, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(2, 18'h00295, 0, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(2, 18'h00295, 0, 10, 1, 1, 8'h01, 0, 0));
        add(0,1,0, 1, pk(2, 18'h00295, 0, 10, 1, 1, 8'h01, 0, 0));
        add(0,0,1, 1, pk(2, 18'h00295, 0, 10, 1, 1, 8'h01, 0, 0));
        add(1,0,0, 1, pk(0, 18'h0,     0, 10, 0, 0, 0,    0, 0));
        // Occupied select, then sel+move together on an empty cell.
        add(1,0,0, 1, pk(0, 18'h00001, 0, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(0, 18'h00001, 1, 10, 0, 0, 0,    0, 0));
        add(1,0,0, 1, pk(0, 18'h00001, 1, 10, 0, 0, 0,    1, 0));
        add(0,0,0, 1, pk(0, 18'h00001, 1, 10, 0, 0, 0,    0, 0));
        add(0,1,0, 1, pk(1, 18'h00001, 1, 10, 0, 0, 0,    0, 0));
        add(1,1,0, 1, pk(1, 18'h00009, 1, 10, 0, 0, 0,    0, 0));
        add(0,0,0, 1, pk(1, 18'h00009, 0, 10, 0, 0, 0,    0, 0));
        // Turn timer: one tick, then down to 1, then expiry.
        add(0,0,1, 1, pk(1, 18'h00009, 0, 9,  0, 0, 0,    0, 0));
        add(0,0,1, 8, pk(1, 18'h00009, 0, 1,  0, 0, 0,    0, 0));
        add(0,0,1, 1, pk(1, 18'h00009, 1, 10, 0, 0, 0,    0, 1));
        add(0,0,0, 1, pk(1, 18'h00009, 1, 10, 0, 0, 0,    0, 0));

        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_bundle(), pk(0, 18'h0, 0, 10, 0, 0, 0, 0, 0));
        rst = 1'b1;

        foreach (vq[k]) begin
            for (int r = 0; r < vq[k].rep; r++) step(vq[k].s, vq[k].m, vq[k].t);
            check($sformatf("table[%0d]", k), dut_bundle(), vq[k].exp);
        end

        // Draw game from a clean board.
        rst = 1'b0; #1; rst = 1'b1; model_reset();
        check("async_reset", dut_bundle(), model_bundle());
        play_cell(0); play_cell(1); play_cell(2); play_cell(4); play_cell(3);
        play_cell(5); play_cell(7); play_cell(6); play_cell(8);
        check("draw_result", {30'h0, game_over, winner, win_line}, {30'h0, 1'b1, 2'b11, 8'h00});
        step(1, 0, 0);
        check("draw_restart", {board, turn, winner}, {18'h0, 1'b0, 2'b00});

        // Reset pulse while the new mark is being scored.
        step(1, 0, 0);
        check("pre_reset_mark", {14'h0, board}, {14'h0, 18'h00001});
        rst = 1'b0;
        #1;
        check("reset_mid_check", dut_bundle(), pk(0, 18'h0, 0, 10, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        step(0, 0, 0);
        check("not_scored", dut_bundle(), pk(0, 18'h0, 0, 10, 0, 0, 0, 0, 0));

        // Random pulses against the model.
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
